// File: rtl/fsm_req_arbiter_if.sv
// Request/completion and controlled-FSM signal bundle for fsm_req_arbiter.
// slave = arbiter side, master = requesters plus the controlled FSM.
interface fsm_req_arbiter_if;
    logic       req0_valid;
    logic [1:0] req0_target;
    logic       req0_ready;
    logic       req1_valid;
    logic [1:0] req1_target;
    logic       req1_ready;
    logic       fsm_inA;
    logic       fsm_inB;
    logic       fsm_outA;
    logic       fsm_outB;
    logic       busy;
    logic       done;
    logic       done_id;
    logic       done_ok;

    modport master (
        output req0_valid, req0_target, req1_valid, req1_target, fsm_outA, fsm_outB,
        input  req0_ready, req1_ready, fsm_inA, fsm_inB, busy, done, done_id, done_ok
    );

    modport slave (
        input  req0_valid, req0_target, req1_valid, req1_target, fsm_outA, fsm_outB,
        output req0_ready, req1_ready, fsm_inA, fsm_inB, busy, done, done_id, done_ok
    );
endinterface

// File: rtl/fsm_req_arbiter.sv
// Arbitrates two requesters for one shared 4-state FSM and pulses inA/inB until its outputs match the target.
// Define FSM_ARB_FIXED_PRIORITY_EN for fixed priority (req0 wins); default build is round-robin.
module fsm_req_arbiter #(
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_STEPS     = 3
) (
    input logic                 clk,
    input logic                 reset,
    fsm_req_arbiter_if.slave    bus
);
    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_DRIVE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             state;
    logic               ptr;
    logic [1:0]         target;
    logic               id;
    logic [1:0]         steps;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               gnt0;
    logic               gnt1;
    logic [1:0]         diff;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt0 = !ptr;
            gnt1 = ptr;
        end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign bus.req0_ready = reset && (state == ST_IDLE) && gnt0;
    assign bus.req1_ready = reset && (state == ST_IDLE) && gnt1;

    assign diff = {bus.fsm_outA, bus.fsm_outB} ^ target;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ptr         <= 1'b0;
            target      <= 2'b00;
            id          <= 1'b0;
            steps       <= 2'b00;
            wait_cnt    <= '0;
            bus.fsm_inA <= 1'b0;
            bus.fsm_inB <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.done_ok <= 1'b0;
        end else begin
            bus.fsm_inA <= 1'b0;
            bus.fsm_inB <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.done_ok <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        target   <= gnt1 ? bus.req1_target : bus.req0_target;
                        id       <= gnt1;
`ifdef FSM_ARB_FIXED_PRIORITY_EN
                        ptr      <= 1'b0;
`else
                        ptr      <= !gnt1;
`endif
                        steps    <= 2'b00;
                        bus.busy <= 1'b1;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (diff == 2'b00) begin
                        bus.done    <= 1'b1;
                        bus.done_id <= id;
                        bus.done_ok <= 1'b1;
                        state       <= ST_DONE;
                    end else if (steps == 2'(MAX_STEPS)) begin
                        bus.done    <= 1'b1;
                        bus.done_id <= id;
                        bus.done_ok <= 1'b0;
                        state       <= ST_DONE;
                    end else begin
                        // diff 01 needs inA; 11 and 10 take inB (10 then becomes 01).
                        bus.fsm_inA <= !diff[1];
                        bus.fsm_inB <= diff[1];
                        state       <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    steps    <= steps + 2'd1;
                    wait_cnt <= WAIT_W'(SETTLE_CYCLES - 1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_CALC;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fsm_req_arbiter.sv
// Randomized and directed bench for fsm_req_arbiter with a request-level reference model.
module tb_fsm_req_arbiter;
    localparam int SETTLE = 1;
    localparam int MAXS   = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fsm_req_arbiter_if bus();

    fsm_req_arbiter #(.SETTLE_CYCLES(SETTLE), .MAX_STEPS(MAXS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Controlled FSM: inA flips bit0, inB flips both bits; optionally stuck at 00.
    logic [1:0] code = 2'b00;
    logic       preset = 1'b0;
    logic [1:0] preset_val = 2'b00;
    logic       stuck = 1'b0;

    always @(posedge clk) begin
        if (preset) code <= preset_val;
        else if (bus.fsm_inA) code <= code ^ 2'b01;
        else if (bus.fsm_inB) code <= code ^ 2'b11;
    end

    assign bus.fsm_outA = stuck ? 1'b0 : code[1];
    assign bus.fsm_outB = stuck ? 1'b0 : code[0];

    int n_chk = 0;
    int n_fail = 0;
    int ptr_m = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef FSM_ARB_FIXED_PRIORITY_EN
            return 0;
`else
            return ptr_m;
`endif
        end
        return v1 ? 1 : 0;
    endfunction

    task automatic set_code(input logic [1:0] v);
        @(posedge clk); #1;
        preset_val = v;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
    endtask

    task automatic drop_valids();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic run_req(input bit v0, input logic [1:0] t0, input bit v1,
                           input logic [1:0] t1, input bit keep);
        int g, cyc, lat, nsteps;
        logic [1:0] c, t, d;
        int ep[$];
        int ec[$];
        int gp[$];
        int gc[$];
        bit ok_e, bad_busy, bad_rdy, both, got;
        bad_busy = 0; bad_rdy = 0; both = 0; got = 0;
        @(posedge clk); #1;
        bus.req0_valid = v0; bus.req0_target = t0;
        bus.req1_valid = v1; bus.req1_target = t1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                got = 1;
                break;
            end
        end
        chk("grant_seen", 32'(got), 1);
        if (!got) begin
            drop_valids();
            return;
        end
        g = pick(v0, v1);
        chk("grant_id", 32'(bus.req1_ready), 32'(g));
        chk("ready_onehot", 32'(bus.req0_ready ^ bus.req1_ready), 1);
`ifndef FSM_ARB_FIXED_PRIORITY_EN
        ptr_m = (g == 0) ? 1 : 0;
`endif
        // Expected pulse plan from the toggle rules, one step per pulse.
        t = (g == 1) ? t1 : t0;
        c = stuck ? 2'b00 : code;
        nsteps = 0;
        ok_e = 0;
        forever begin
            d = c ^ t;
            if (d == 2'b00) begin ok_e = 1; break; end
            if (nsteps == MAXS) begin ok_e = 0; break; end
            ep.push_back((d == 2'b01) ? 0 : 1);
            ec.push_back(2 + nsteps * (2 + SETTLE));
            if (!stuck) c = (d == 2'b01) ? (c ^ 2'b01) : (c ^ 2'b11);
            nsteps++;
        end
        lat = 2 + nsteps * (2 + SETTLE);

        @(posedge clk); #1;
        if (!keep) drop_valids();
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (bus.fsm_inA || bus.fsm_inB) begin
                gp.push_back(bus.fsm_inB ? 1 : 0);
                gc.push_back(cyc);
            end
            if (bus.fsm_inA && bus.fsm_inB) both = 1;
            if (!bus.busy) bad_busy = 1;
            if (bus.req0_ready || bus.req1_ready) bad_rdy = 1;
            if (bus.done) break;
        end
        chk("done_latency", 32'(cyc), 32'(lat));
        chk("done_id", 32'(bus.done_id), 32'(g));
        chk("done_ok", 32'(bus.done_ok), 32'(ok_e));
        chk("pulse_count", 32'(gp.size()), 32'(ep.size()));
        for (int k = 0; k < ep.size() && k < gp.size(); k++) begin
            chk("pulse_kind", 32'(gp[k]), 32'(ep[k]));
            chk("pulse_cycle", 32'(gc[k]), 32'(ec[k]));
        end
        chk("inA_inB_overlap", 32'(both), 0);
        chk("busy_during_req", 32'(bad_busy), 0);
        chk("ready_while_busy", 32'(bad_rdy), 0);
        if (!stuck) chk("final_code", 32'(code), 32'(t));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        int vsel;
        bus.req0_valid = 1'b1;
        bus.req0_target = 2'b01;
        bus.req1_valid = 1'b0;
        bus.req1_target = 2'b00;
        #12;
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_fsm_in", 32'({bus.fsm_inA, bus.fsm_inB}), 0);
        drop_valids();
        @(posedge clk); #1;
        reset = 1'b1;

        // Single inA step, inB+inA sequence, then round-robin alternation.
        set_code(2'b00);
        run_req(1, 2'b01, 0, 2'b00, 0);
        set_code(2'b00);
        run_req(0, 2'b00, 1, 2'b10, 0);
        chk("end_in_E2", 32'(code), 2);
        for (int i = 0; i < 4; i++) run_req(1, 2'b11, 1, 2'b00, 1);
        @(posedge clk); #1;
        drop_valids();

        // Already at target, then a stuck FSM exhausting the step budget.
        set_code(2'b11);
        run_req(1, 2'b11, 0, 2'b00, 0);
        stuck = 1'b1;
        run_req(1, 2'b01, 0, 2'b00, 0);
        stuck = 1'b0;

        // Reset while waiting for the FSM to settle.
        set_code(2'b00);
        @(posedge clk); #1;
        bus.req0_valid = 1'b1;
        bus.req0_target = 2'b01;
        @(negedge clk);
        chk("pre_rst_grant", 32'(bus.req0_ready), 1);
        @(posedge clk); #1;
        drop_valids();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_fsm_in", 32'({bus.fsm_inA, bus.fsm_inB}), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1;
        end
        chk("no_done_after_rst", 32'(seen_done), 0);
        ptr_m = 0;
        run_req(1, 2'b10, 0, 2'b00, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 30; i++) begin
            stuck = ($urandom_range(0, 4) == 0);
            set_code(2'($urandom_range(0, 3)));
            vsel = $urandom_range(1, 3);
            run_req(vsel[0], 2'($urandom_range(0, 3)), vsel[1], 2'($urandom_range(0, 3)), 0);
        end
        stuck = 1'b0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
